// File: rtl/mdr_pkg.sv
// mdr_pkg -- shared definitions for the memory data register block.
//   mdr_state_e   : handshake FSM encoding (IDLE = 0, RD_REQ = 1, WR_REQ = 2)
//   MDR_*_DEF     : default parameter values for the 16-bit datapath
//   cnt_width()   : width of an occupancy count able to hold 0..depth
//   ptr_width()   : width of a pointer indexing depth entries
package mdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2
    } mdr_state_e;

    localparam int unsigned MDR_WIDTH_DEF   = 16;
    localparam int unsigned MDR_DEPTH_DEF   = 4;
    localparam int unsigned MDR_TIMEOUT_DEF = 15;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- small synchronous FIFO holding burst-read words.
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (dropped only if truly full)
//   push_data  : word to store
//   pop        : discard the head word (no-op when empty)
//   head       : combinational view of the oldest word
//   count      : number of words held, 0..DEPTH
module sync_fifo
    import mdr_pkg::*;
#(
    parameter int unsigned WIDTH = MDR_WIDTH_DEF,
    parameter int unsigned DEPTH = MDR_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count_q != '0);
    // A full FIFO can still take a word if the head leaves in the same cycle.
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mdr_burst.sv
// mdr_burst -- memory data register with burst-read buffer and write-back.
//   clk, rst           : clock, synchronous active-high reset
//   bus_in/bus_load_en : load the register from the internal bus
//   bus_out/bus_oe_en  : tri-state drive of the register onto the bus
//   mdr_data           : register value, always driven
//   pop                : move the buffer head into the register
//   mem_rd_start       : start a burst read of burst_len (1..DEPTH) words
//   mem_wr_start       : start a single-word write of the register
//   mem_req/mem_we     : request to memory, direction (1 = write)
//   mem_ack/mem_rdata  : memory accepts/returns one word this cycle
//   mem_wdata          : write data (the register value)
//   mem_addr_inc       : one pulse per accepted word, advances the MAR
//   busy, done         : FSM not idle; pulse the cycle after the last ack
//   buf_count          : words waiting in the burst buffer
//   cmd_err            : pulse when a start is rejected
//   timeout_err        : sticky stalled-memory flag, cleared by an accepted start
//
// Handshake: mem_req stays high from the accepting edge until the edge on
// which mem_ack is seen (or the wait budget runs out); every cycle with
// mem_req = 1 and mem_ack = 1 transfers exactly one word.
module mdr_burst
    import mdr_pkg::*;
#(
    parameter int unsigned WIDTH   = MDR_WIDTH_DEF,
    parameter int unsigned DEPTH   = MDR_DEPTH_DEF,
    parameter int unsigned TIMEOUT = MDR_TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              bus_in,
    input  logic                          bus_load_en,
    output wire  [WIDTH-1:0]              bus_out,
    input  logic                          bus_oe_en,
    output logic [WIDTH-1:0]              mdr_data,
    input  logic                          pop,
    input  logic                          mem_rd_start,
    input  logic                          mem_wr_start,
    input  logic [cnt_width(DEPTH)-1:0]   burst_len,
    output logic                          mem_req,
    output logic                          mem_we,
    input  logic                          mem_ack,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic [WIDTH-1:0]              mem_wdata,
    output logic                          mem_addr_inc,
    output logic                          busy,
    output logic                          done,
    output logic [cnt_width(DEPTH)-1:0]   buf_count,
    output logic                          cmd_err,
    output logic                          timeout_err
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    mdr_state_e       state_q, state_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;
    logic             timeout_err_q, timeout_err_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             len_ok;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (buf_count)
    );

    assign len_ok = (burst_len != '0) && (burst_len <= CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            wait_cnt_q    <= '0;
            mdr_q         <= '0;
            done_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            wait_cnt_q    <= wait_cnt_d;
            mdr_q         <= mdr_d;
            done_q        <= done_d;
            cmd_err_q     <= cmd_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        wait_cnt_d    = wait_cnt_q;
        done_d        = 1'b0;
        cmd_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        fifo_push     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_rd_start && mem_wr_start) begin
                    cmd_err_d = 1'b1;
                end else if (mem_rd_start) begin
                    // An empty buffer guarantees the whole burst fits.
                    if (len_ok && (buf_count == '0)) begin
                        state_d       = ST_RD_REQ;
                        remaining_d   = burst_len;
                        wait_cnt_d    = '0;
                        timeout_err_d = 1'b0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (mem_wr_start) begin
                    state_d       = ST_WR_REQ;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_RD_REQ: begin
                if (mem_ack) begin
                    fifo_push   = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    wait_cnt_d  = '0;
                    if (remaining_q == CW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (wait_cnt_q == TW'(TIMEOUT)) begin
                    // Abort; words already buffered stay poppable.
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (wait_cnt_q == TW'(TIMEOUT)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The register is frozen during a write so mem_wdata stays stable.
    always_comb begin
        mdr_d    = mdr_q;
        fifo_pop = pop && (buf_count != '0) && (state_q != ST_WR_REQ);
        if (fifo_pop) begin
            mdr_d = fifo_head;
        end else if (bus_load_en && (state_q != ST_WR_REQ)) begin
            mdr_d = bus_in;
        end
    end

    assign bus_out      = bus_oe_en ? mdr_q : {WIDTH{1'bz}};
    assign mdr_data     = mdr_q;
    assign mem_wdata    = mdr_q;
    assign mem_req      = (state_q != ST_IDLE);
    assign mem_we       = (state_q == ST_WR_REQ);
    assign mem_addr_inc = (state_q != ST_IDLE) && mem_ack;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign cmd_err      = cmd_err_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mdr_burst.sv
// tb_mdr_burst -- self-checking bench for mdr_burst.
// Inputs change just after a falling edge; outputs are observed on falling
// edges (registered values) or 1 ns after an input change (combinational).
// The reference keeps the buffer as a queue of words and the register as a
// single expected value, updated from the behavioural rules per rising edge.
module tb_mdr_burst;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int CW      = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [WIDTH-1:0] bus_in;
    logic             bus_load_en;
    wire  [WIDTH-1:0] bus_out;
    logic             bus_oe_en;
    logic [WIDTH-1:0] mdr_data;
    logic             pop;
    logic             mem_rd_start;
    logic             mem_wr_start;
    logic [CW-1:0]    burst_len;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_addr_inc;
    logic             busy;
    logic             done;
    logic [CW-1:0]    buf_count;
    logic             cmd_err;
    logic             timeout_err;

    mdr_burst #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (bus_in),
        .bus_load_en  (bus_load_en),
        .bus_out      (bus_out),
        .bus_oe_en    (bus_oe_en),
        .mdr_data     (mdr_data),
        .pop          (pop),
        .mem_rd_start (mem_rd_start),
        .mem_wr_start (mem_wr_start),
        .burst_len    (burst_len),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_addr_inc (mem_addr_inc),
        .busy         (busy),
        .done         (done),
        .buf_count    (buf_count),
        .cmd_err      (cmd_err),
        .timeout_err  (timeout_err)
    );

    // ---------------- reference model state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_mdr;
    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_bus(input logic [WIDTH-1:0] v);
        bus_in      = v;
        bus_load_en = 1'b1;
        tick();
        bus_load_en = 1'b0;
        exp_mdr     = v;
    endtask

    // Pops every buffered word and compares each against the queue model.
    task automatic pop_all();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2 * DEPTH) begin
            guard++;
            pop     = 1'b1;
            exp_mdr = exp_q.pop_front();
            tick();
            pop = 1'b0;
            n_cmp++;
            if (mdr_data !== exp_mdr) begin
                n_fail++;
                $display("FAIL pop_data: got %h want %h", mdr_data, exp_mdr);
            end
            n_cmp++;
            if (buf_count !== CW'(exp_q.size())) begin
                n_fail++;
                $display("FAIL pop_count: got %0d want %0d", buf_count, exp_q.size());
            end
        end
    endtask

    // Burst read of len words. rnd: random data and ack gaps (never long
    // enough to time out). with_pop: random pops while the burst runs.
    task automatic run_burst(input int len, input bit rnd, input bit with_pop);
        int k, guard, gap;
        bit ack;
        logic [WIDTH-1:0] d;
        burst_len    = CW'(len);
        mem_rd_start = 1'b1;
        tick();
        mem_rd_start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_accept: busy/req/we got %b%b%b want 110", busy, mem_req, mem_we);
        end
        k = 0; guard = 0; gap = 0;
        while (k < len && guard < 200) begin
            guard++;
            ack = rnd ? ($urandom_range(0, 3) != 0 || gap >= 4) : 1'b1;
            gap = ack ? 0 : gap + 1;
            d   = rnd ? WIDTH'($urandom) : WIDTH'(16'h1111 * (k + 1));
            mem_ack   = ack;
            mem_rdata = d;
            pop       = with_pop ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr_inc !== ack || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_cycle: req/inc/done got %b%b%b want 1%b0", mem_req, mem_addr_inc, done, ack);
            end
            // pop sees the buffer as it was before this edge's push
            if (pop && exp_q.size() > 0) exp_mdr = exp_q.pop_front();
            if (ack) begin
                exp_q.push_back(d);
                k++;
            end
            tick();
            mem_ack = 1'b0;
            pop     = 1'b0;
            n_cmp++;
            if (mdr_data !== exp_mdr || buf_count !== CW'(exp_q.size())) begin
                n_fail++;
                $display("FAIL rd_model: mdr %h cnt %0d want %h %0d", mdr_data, buf_count, exp_mdr, exp_q.size());
            end
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done: done/busy/req got %b%b%b want 100", done, busy, mem_req);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done_pulse: got %b want 0", done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++;
        if (mdr_data !== '0 || buf_count !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: mdr %h cnt %0d want 0 0", mdr_data, buf_count);
        end
        n_cmp++;
        if ({mem_req, mem_we, done, mem_addr_inc, cmd_err, timeout_err, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {mem_req, mem_we, done, mem_addr_inc, cmd_err, timeout_err, busy});
        end
    endtask

    task automatic test_bus_load();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < 6; i++) begin
            v = (i == 0) ? WIDTH'(16'h00A5) : (WIDTH'($urandom) | WIDTH'(1));
            load_bus(v);
            bus_oe_en = 1'b1;
            #1;
            n_cmp++;
            if (bus_out !== exp_mdr || mdr_data !== exp_mdr) begin
                n_fail++;
                $display("FAIL bus_drive: bus %h mdr %h want %h", bus_out, mdr_data, exp_mdr);
            end
            bus_oe_en = 1'b0;
            #1;
            n_cmp++;
            if ((bus_out !== {WIDTH{1'bz}} && bus_out !== '0) || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL bus_release: bus %h req %b want z 0", bus_out, mem_req);
            end
        end
    endtask

    task automatic test_burst_fixed();
        run_burst(3, 1'b0, 1'b0);
        pop_all();
    endtask

    task automatic test_burst_random();
        for (int i = 0; i < 8; i++) begin
            run_burst(int'($urandom_range(1, DEPTH)), 1'b1, (i % 2) == 1);
            pop_all();
        end
        // pop on an empty buffer changes nothing
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++;
        if (mdr_data !== exp_mdr || buf_count !== '0) begin
            n_fail++;
            $display("FAIL empty_pop: mdr %h cnt %0d want %h 0", mdr_data, buf_count, exp_mdr);
        end
    endtask

    task automatic test_write();
        run_burst(1, 1'b1, 1'b0);  // leave one word buffered
        load_bus(16'hBEEF);
        mem_wr_start = 1'b1;
        tick();
        mem_wr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_in      = WIDTH'($urandom);
            bus_load_en = 1'b1;
            pop         = 1'b1;
            #1;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_wait: req %b we %b wdata %h inc %b want 1 1 beef 0",
                         mem_req, mem_we, mem_wdata, mem_addr_inc);
            end
            tick();
            n_cmp++;
            if (mdr_data !== 16'hBEEF || buf_count !== CW'(1)) begin
                n_fail++;
                $display("FAIL wr_frozen: mdr %h cnt %0d want beef 1", mdr_data, buf_count);
            end
        end
        bus_load_en = 1'b0;
        pop         = 1'b0;
        mem_ack     = 1'b1;
        #1;
        n_cmp++;
        if (mem_addr_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_inc: got %b want 1", mem_addr_inc);
        end
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || mdr_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL wr_done: done %b busy %b mdr %h want 1 0 beef", done, busy, mdr_data);
        end
        pop_all();
    endtask

    task automatic test_timeout();
        int hi;
        bit saw_done;
        logic [WIDTH-1:0] d;
        burst_len    = CW'(2);
        mem_rd_start = 1'b1;
        tick();
        mem_rd_start = 1'b0;
        d         = WIDTH'($urandom);
        mem_ack   = 1'b1;
        mem_rdata = d;
        exp_q.push_back(d);
        tick();
        mem_ack  = 1'b0;
        hi       = 0;
        saw_done = 1'b0;
        while (mem_req === 1'b1 && hi < 100) begin
            if (done === 1'b1) saw_done = 1'b1;
            hi++;
            tick();
        end
        // wait budget: TIMEOUT cycles counting up, then one more to abort
        n_cmp++;
        if (hi != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL to_length: req high %0d cycles want %0d", hi, TIMEOUT + 1);
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || buf_count !== CW'(1) || done !== 1'b0 || saw_done) begin
            n_fail++;
            $display("FAIL to_state: terr %b cnt %0d done %b/%b want 1 1 0/0",
                     timeout_err, buf_count, done, saw_done);
        end
        // a rejected start leaves the sticky flag alone
        burst_len    = CW'(1);
        mem_rd_start = 1'b1;
        tick();
        mem_rd_start = 1'b0;
        n_cmp++;
        if (cmd_err !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_sticky: cmd_err %b terr %b busy %b want 1 1 0", cmd_err, timeout_err, busy);
        end
        pop_all();
        mem_wr_start = 1'b1;
        tick();
        mem_wr_start = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_clear: terr %b busy %b want 0 1", timeout_err, busy);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL to_clear_done: got %b want 1", done);
        end
    endtask

    task automatic test_rejects();
        for (int c = 0; c < 5; c++) begin
            if (c == 4) run_burst(1, 1'b1, 1'b0);
            case (c)
                0: begin burst_len = CW'(0); mem_rd_start = 1'b1; end
                1: begin burst_len = CW'(5); mem_rd_start = 1'b1; end
                2: begin burst_len = CW'($urandom_range(6, 7)); mem_rd_start = 1'b1; end
                3: begin burst_len = CW'(2); mem_rd_start = 1'b1; mem_wr_start = 1'b1; end
                default: begin burst_len = CW'(1); mem_rd_start = 1'b1; end
            endcase
            tick();
            mem_rd_start = 1'b0;
            mem_wr_start = 1'b0;
            n_cmp++;
            if (cmd_err !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_%0d: cmd_err %b busy %b req %b want 1 0 0", c, cmd_err, busy, mem_req);
            end
            tick();
            n_cmp++;
            if (cmd_err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_pulse_%0d: cmd_err %b busy %b want 0 0", c, cmd_err, busy);
            end
        end
        pop_all();
    endtask

    task automatic test_reset_mid_burst();
        load_bus(WIDTH'($urandom) | WIDTH'(1));
        burst_len    = CW'(4);
        mem_rd_start = 1'b1;
        tick();
        mem_rd_start = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = WIDTH'($urandom);
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (buf_count !== CW'(1) || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: cnt %0d req %b want 1 1", buf_count, mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_mdr = '0;
        n_cmp++;
        if (mem_req !== 1'b0 || buf_count !== '0 || mdr_data !== exp_mdr || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: req %b cnt %0d mdr %h busy %b want 0 0 0 0",
                     mem_req, buf_count, mdr_data, busy);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle: req %b done %b want 0 0", mem_req, done);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst          = 1'b1;
        bus_in       = '0;
        bus_load_en  = 1'b0;
        bus_oe_en    = 1'b0;
        pop          = 1'b0;
        mem_rd_start = 1'b0;
        mem_wr_start = 1'b0;
        burst_len    = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        exp_mdr      = '0;
        tick();
        tick();
        rst = 1'b0;

        test_reset();
        test_bus_load();
        test_burst_fixed();
        test_burst_random();
        test_write();
        test_timeout();
        test_rejects();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
